sal_sched_rr: RTL and testbench

- Parametrised next-generation DRAM command scheduler between the per-bank controllers and the DRAM command encoder.
- Selects at most one command per cycle among ACT/RD/WR/PRE/REF requests from BK_CNT banks.
- Enforces inter-bank timing tRRD, tFAW, tCCD, tRTW and tWTR.
- Adds round-robin ACT/PRE arbitration, a tFAW four-activate window, and a read/write mode FSM with write-drain watermarks. Column commands keep per-direction in-order issue by sequence number.

---
 rtl/sal_sched_rr.sv | 208 ++++++++++++++++++++
 tb/tb_sal_sched_rr.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sal_sched_rr.sv
// DRAM command scheduler: picks at most one ACT/RD/WR/PRE/REF per cycle across banks,
// enforcing inter-bank timing, a four-activate window and read/write mode batching.
//
// state   | meaning
// MODE_RD | column slot serves reads only
// MODE_WR | column slot serves writes only (write drain)
module sal_sched_rr #(
  parameter int BK_CNT   = 8,
  parameter int RA_W     = 14,
  parameter int CA_W     = 10,
  parameter int ID_W     = 4,
  parameter int LEN_W    = 4,
  parameter int SEQ_W    = 4,
  parameter int TW       = 5,
  parameter int WR_HI_WM = 4,
  parameter int WR_LO_WM = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [TW-1:0]              t_rrd_m1,
  input  logic [TW-1:0]              t_faw_m1,
  input  logic [TW-1:0]              t_ccd_m1,
  input  logic [TW-1:0]              t_rtw_m1,
  input  logic [TW-1:0]              t_wtr_m1,
  input  logic [BK_CNT-1:0]          act_req,
  input  logic [BK_CNT-1:0]          rd_req,
  input  logic [BK_CNT-1:0]          wr_req,
  input  logic [BK_CNT-1:0]          pre_req,
  input  logic [BK_CNT-1:0]          ref_req,
  input  logic [BK_CNT*RA_W-1:0]     ra_flat,
  input  logic [BK_CNT*CA_W-1:0]     ca_flat,
  input  logic [BK_CNT*ID_W-1:0]     id_flat,
  input  logic [BK_CNT*LEN_W-1:0]    len_flat,
  input  logic [BK_CNT*SEQ_W-1:0]    seq_flat,
  output logic [BK_CNT-1:0]          act_gnt,
  output logic [BK_CNT-1:0]          rd_gnt,
  output logic [BK_CNT-1:0]          wr_gnt,
  output logic [BK_CNT-1:0]          pre_gnt,
  output logic [BK_CNT-1:0]          ref_gnt,
  output logic                       cmd_act,
  output logic                       cmd_rd,
  output logic                       cmd_wr,
  output logic                       cmd_pre,
  output logic                       cmd_ref,
  output logic [$clog2(BK_CNT)-1:0]  cmd_ba,
  output logic [RA_W-1:0]            cmd_ra,
  output logic [CA_W-1:0]            cmd_ca,
  output logic [ID_W-1:0]            cmd_id,
  output logic [LEN_W-1:0]           cmd_len,
  output logic                       wr_mode
);

  localparam int BA_W = $clog2(BK_CNT);

  typedef enum logic {MODE_RD = 1'b0, MODE_WR = 1'b1} mode_e;

  mode_e             mode_q, mode_d;
  logic [TW-1:0]     rrd_cnt, ccd_cnt, rtw_cnt, wtr_cnt;
  logic [TW-1:0]     faw_slot [4];
  logic [3:0]        faw_load;
  logic [BA_W-1:0]   act_ptr, pre_ptr, gnt_ba;
  logic [SEQ_W-1:0]  rd_seq, wr_seq;
  logic [BK_CNT-1:0] act_cand, pre_cand, ref_cand, rd_cand, wr_cand, any_gnt;
  logic              rrd_zero, ccd_zero, rtw_zero, wtr_zero, faw_ok;
  int                nwr;

  function automatic logic [BK_CNT-1:0] rr_pick(input logic [BK_CNT-1:0] req,
                                                input logic [BA_W-1:0]   ptr);
    logic [BK_CNT-1:0] g;
    logic              found;
    int                idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < BK_CNT; k++) begin
      idx = int'(ptr) + k;
      if (idx >= BK_CNT) idx = idx - BK_CNT;
      if (!found && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  function automatic logic [BA_W-1:0] ptr_inc(input logic [BA_W-1:0] ba);
    return (ba == BA_W'(BK_CNT - 1)) ? '0 : ba + 1'b1;
  endfunction

  assign rrd_zero = (rrd_cnt == '0);
  assign ccd_zero = (ccd_cnt == '0);
  assign rtw_zero = (rtw_cnt == '0);
  assign wtr_zero = (wtr_cnt == '0);

  // Newly freed slot with the lowest index takes the next activate
  always_comb begin
    faw_ok   = 1'b0;
    faw_load = '0;
    for (int s = 3; s >= 0; s--) begin
      if (faw_slot[s] == '0) begin
        faw_ok   = 1'b1;
        faw_load = 4'b0001 << s;
      end
    end
  end

  always_comb begin
    act_cand = rr_pick(act_req, act_ptr);
    pre_cand = rr_pick(pre_req, pre_ptr);
    ref_cand = '0;
    rd_cand  = '0;
    wr_cand  = '0;
    for (int i = BK_CNT - 1; i >= 0; i--) begin
      if (ref_req[i]) ref_cand = BK_CNT'(1) << i;
      if (rd_req[i] && seq_flat[i*SEQ_W +: SEQ_W] == rd_seq) rd_cand = BK_CNT'(1) << i;
      if (wr_req[i] && seq_flat[i*SEQ_W +: SEQ_W] == wr_seq) wr_cand = BK_CNT'(1) << i;
    end
  end

  always_comb begin
    act_gnt = '0;
    rd_gnt  = '0;
    wr_gnt  = '0;
    pre_gnt = '0;
    ref_gnt = '0;
    if (!rst) begin
      if (rrd_zero && faw_ok && (act_cand != '0))
        act_gnt = act_cand;
      else if (mode_q == MODE_RD && ccd_zero && wtr_zero && (rd_cand != '0))
        rd_gnt = rd_cand;
      else if (mode_q == MODE_WR && ccd_zero && rtw_zero && (wr_cand != '0))
        wr_gnt = wr_cand;
      else if (pre_cand != '0)
        pre_gnt = pre_cand;
      else if (rrd_zero && (ref_cand != '0))
        ref_gnt = ref_cand;
    end
  end

  assign cmd_act = |act_gnt;
  assign cmd_rd  = |rd_gnt;
  assign cmd_wr  = |wr_gnt;
  assign cmd_pre = |pre_gnt;
  assign cmd_ref = |ref_gnt;
  assign any_gnt = act_gnt | rd_gnt | wr_gnt | pre_gnt | ref_gnt;

  always_comb begin
    gnt_ba  = '0;
    cmd_ra  = '0;
    cmd_ca  = '0;
    cmd_id  = '0;
    cmd_len = '0;
    for (int i = 0; i < BK_CNT; i++) begin
      if (any_gnt[i]) begin
        gnt_ba  = BA_W'(i);
        cmd_ra  = ra_flat[i*RA_W +: RA_W];
        cmd_ca  = ca_flat[i*CA_W +: CA_W];
        cmd_id  = id_flat[i*ID_W +: ID_W];
        cmd_len = len_flat[i*LEN_W +: LEN_W];
      end
    end
  end

  assign cmd_ba = gnt_ba;

  always_comb begin
    nwr    = $countones(wr_req);
    mode_d = mode_q;
    case (mode_q)
      MODE_RD: if (nwr >= WR_HI_WM || (rd_req == '0 && wr_req != '0)) mode_d = MODE_WR;
      MODE_WR: if (rd_req != '0 && (nwr <= WR_LO_WM || wr_req == '0)) mode_d = MODE_RD;
      default: mode_d = MODE_RD;
    endcase
  end

  assign wr_mode = (mode_q == MODE_WR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_RD;
      rrd_cnt <= '0;
      ccd_cnt <= '0;
      rtw_cnt <= '0;
      wtr_cnt <= '0;
      for (int s = 0; s < 4; s++) faw_slot[s] <= '0;
      act_ptr <= '0;
      pre_ptr <= '0;
      rd_seq  <= '0;
      wr_seq  <= '0;
    end else begin
      mode_q  <= mode_d;
      rrd_cnt <= cmd_act ? t_rrd_m1 : dec_sat(rrd_cnt);
      ccd_cnt <= (cmd_rd || cmd_wr) ? t_ccd_m1 : dec_sat(ccd_cnt);
      rtw_cnt <= cmd_rd ? t_rtw_m1 : dec_sat(rtw_cnt);
      wtr_cnt <= cmd_wr ? t_wtr_m1 : dec_sat(wtr_cnt);
      for (int s = 0; s < 4; s++)
        faw_slot[s] <= (cmd_act && faw_load[s]) ? t_faw_m1 : dec_sat(faw_slot[s]);
      if (cmd_act) act_ptr <= ptr_inc(gnt_ba);
      if (cmd_pre) pre_ptr <= ptr_inc(gnt_ba);
      if (cmd_rd)  rd_seq  <= rd_seq + 1'b1;
      if (cmd_wr)  wr_seq  <= wr_seq + 1'b1;
    end
  end

endmodule

// File: tb/tb_sal_sched_rr.sv
// Directed bench for sal_sched_rr: arbitration, timing windows, mode FSM, seq order, async reset.
module tb_sal_sched_rr;
  localparam int BK = 8, RA_W = 14, CA_W = 10, ID_W = 4, LEN_W = 4, SEQ_W = 4, TW = 5;

  logic clk = 1'b0;
  logic rst;
  logic [TW-1:0] t_rrd_m1, t_faw_m1, t_ccd_m1, t_rtw_m1, t_wtr_m1;
  logic [BK-1:0] act_req, rd_req, wr_req, pre_req, ref_req;
  logic [BK*RA_W-1:0]  ra_flat;
  logic [BK*CA_W-1:0]  ca_flat;
  logic [BK*ID_W-1:0]  id_flat;
  logic [BK*LEN_W-1:0] len_flat;
  logic [BK*SEQ_W-1:0] seq_flat;
  logic [BK-1:0] act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic cmd_act, cmd_rd, cmd_wr, cmd_pre, cmd_ref, wr_mode;
  logic [2:0] cmd_ba;
  logic [RA_W-1:0] cmd_ra;
  logic [CA_W-1:0] cmd_ca;
  logic [ID_W-1:0] cmd_id;
  logic [LEN_W-1:0] cmd_len;

  int checks = 0;
  int failures = 0;

  sal_sched_rr #(
    .BK_CNT(BK), .RA_W(RA_W), .CA_W(CA_W), .ID_W(ID_W), .LEN_W(LEN_W),
    .SEQ_W(SEQ_W), .TW(TW), .WR_HI_WM(4), .WR_LO_WM(1)
  ) dut (
    .clk(clk), .rst(rst),
    .t_rrd_m1(t_rrd_m1), .t_faw_m1(t_faw_m1), .t_ccd_m1(t_ccd_m1),
    .t_rtw_m1(t_rtw_m1), .t_wtr_m1(t_wtr_m1),
    .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req), .pre_req(pre_req), .ref_req(ref_req),
    .ra_flat(ra_flat), .ca_flat(ca_flat), .id_flat(id_flat), .len_flat(len_flat),
    .seq_flat(seq_flat),
    .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
    .cmd_act(cmd_act), .cmd_rd(cmd_rd), .cmd_wr(cmd_wr), .cmd_pre(cmd_pre), .cmd_ref(cmd_ref),
    .cmd_ba(cmd_ba), .cmd_ra(cmd_ra), .cmd_ca(cmd_ca), .cmd_id(cmd_id), .cmd_len(cmd_len),
    .wr_mode(wr_mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr_req();
    act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
  endtask

  task automatic set_seq(input int b, input logic [SEQ_W-1:0] v);
    seq_flat[b*SEQ_W +: SEQ_W] = v;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  logic [BK-1:0] e1 [9];
  logic [BK-1:0] exp_act;

  initial begin
    rst = 1'b1;
    clr_req();
    t_rrd_m1 = '0; t_faw_m1 = '0; t_ccd_m1 = '0; t_rtw_m1 = '0; t_wtr_m1 = '0;
    seq_flat = '0; ca_flat = '0; len_flat = '0;
    for (int i = 0; i < BK; i++) begin
      ra_flat[i*RA_W +: RA_W] = RA_W'(14'h100 + i);
      id_flat[i*ID_W +: ID_W] = ID_W'(i);
    end
    #2;
    act_req = 8'hFF;
    pre_req = 8'hFF;
    settle();
    chk("rst_gnt", {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}, 40'h0);
    chk("rst_mode", wr_mode, 1'b0);
    tick();
    rst = 1'b0;
    clr_req();

    // tRRD with round-robin pointer
    t_rrd_m1 = 5'd3;
    act_req = 8'h24;
    e1 = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h04};
    for (int c = 0; c < 9; c++) begin
      settle();
      chk($sformatf("rrd_act_c%0d", c), act_gnt, e1[c]);
      if (c == 0) begin
        chk("rrd_ba_c0", cmd_ba, 3'd2);
        chk("rrd_ra_c0", cmd_ra, 14'h102);
      end
      if (c == 1) chk("idle_fields", {cmd_ba, cmd_ra, cmd_id}, 0);
      if (c == 4) chk("rrd_ba_c4", cmd_ba, 3'd5);
      tick();
    end

    // tFAW window, lower classes proceed while ACT is blocked
    clr_req();
    pulse_rst();
    t_rrd_m1 = 5'd0;
    t_faw_m1 = 5'd15;
    act_req = 8'hFF;
    for (int c = 0; c < 17; c++) begin
      if (c == 4) begin pre_req = 8'h02; ref_req = 8'h01; end
      if (c == 5) begin pre_req = 8'h00; ref_req = 8'h01; end
      if (c == 6) ref_req = 8'h00;
      settle();
      exp_act = (c < 4) ? (8'h01 << c) : ((c == 16) ? 8'h10 : 8'h00);
      chk($sformatf("faw_act_c%0d", c), act_gnt, exp_act);
      if (c == 4) begin
        chk("faw_pre_c4", pre_gnt, 8'h02);
        chk("faw_ref_c4", ref_gnt, 8'h00);
      end
      if (c == 5) chk("faw_ref_c5", ref_gnt, 8'h01);
      tick();
    end

    // Mode FSM with write-drain watermarks
    clr_req();
    pulse_rst();
    t_faw_m1 = 5'd0;
    set_seq(1, 0); set_seq(3, 0); set_seq(2, 1); set_seq(0, 2); set_seq(4, 3);
    rd_req = 8'h02; wr_req = 8'h01;
    settle();
    chk("mode_rd_c0", rd_gnt, 8'h02);
    chk("mode_wr_c0", wr_gnt, 8'h00);
    chk("mode_c0", wr_mode, 1'b0);
    tick();
    set_seq(1, 1); wr_req = 8'h0D;
    settle();
    chk("mode_rd_c1", rd_gnt, 8'h02);
    tick();
    wr_req = 8'h1D;
    settle();
    chk("mode_col_c2", {cmd_rd, cmd_wr}, 2'b00);
    chk("mode_c2", wr_mode, 1'b0);
    tick();
    set_seq(1, 2);
    settle();
    chk("mode_c3", wr_mode, 1'b1);
    chk("mode_wr_c3", wr_gnt, 8'h08);
    chk("mode_nord_c3", rd_gnt, 8'h00);
    tick();
    wr_req = 8'h15;
    settle();
    chk("mode_wr_c4", wr_gnt, 8'h04);
    tick();
    wr_req = 8'h11;
    settle();
    chk("mode_wr_c5", wr_gnt, 8'h01);
    tick();
    wr_req = 8'h10;
    settle();
    chk("mode_wr_c6", wr_gnt, 8'h10);
    chk("mode_c6", wr_mode, 1'b1);
    tick();
    wr_req = 8'h00;
    settle();
    chk("mode_c7", wr_mode, 1'b0);
    chk("mode_rd_c7", rd_gnt, 8'h02);
    tick();

    // tWTR then tRTW turnaround
    clr_req();
    pulse_rst();
    t_wtr_m1 = 5'd5;
    t_rtw_m1 = 5'd2;
    set_seq(0, 0); set_seq(1, 0);
    wr_req = 8'h01;
    settle();
    chk("wtr_nowr_c0", cmd_wr, 1'b0);
    tick();
    rd_req = 8'h02;
    settle();
    chk("wtr_mode_c1", wr_mode, 1'b1);
    chk("wtr_wr_c1", wr_gnt, 8'h01);
    tick();
    wr_req = 8'h00;
    for (int c = 2; c < 7; c++) begin
      settle();
      chk($sformatf("wtr_nord_c%0d", c), cmd_rd, 1'b0);
      if (c == 2) chk("wtr_mode_c2", wr_mode, 1'b0);
      tick();
    end
    settle();
    chk("wtr_rd_c7", rd_gnt, 8'h02);
    tick();
    rd_req = 8'h00; wr_req = 8'h01; set_seq(0, 1);
    settle();
    chk("rtw_nowr_c8", cmd_wr, 1'b0);
    tick();
    settle();
    chk("rtw_mode_c9", wr_mode, 1'b1);
    chk("rtw_nowr_c9", cmd_wr, 1'b0);
    tick();
    settle();
    chk("rtw_wr_c10", wr_gnt, 8'h01);
    tick();

    // Read sequence ordering and wrap
    clr_req();
    pulse_rst();
    t_wtr_m1 = 5'd0;
    t_rtw_m1 = 5'd0;
    set_seq(3, 1); set_seq(6, 0);
    rd_req = 8'h48;
    settle();
    chk("seq_first", rd_gnt, 8'h40);
    chk("seq_first_id", cmd_id, 4'd6);
    chk("seq_first_ba", cmd_ba, 3'd6);
    tick();
    settle();
    chk("seq_second", rd_gnt, 8'h08);
    tick();
    rd_req = 8'h20;
    for (int k = 2; k < 18; k++) begin
      set_seq(5, SEQ_W'(k));
      settle();
      chk($sformatf("seq_run_%0d", k), rd_gnt, 8'h20);
      tick();
    end
    set_seq(5, 3);
    settle();
    chk("seq_mismatch", cmd_rd, 1'b0);
    tick();

    // Asynchronous reset mid-operation
    clr_req();
    pulse_rst();
    t_rrd_m1 = 5'd7;
    set_seq(2, 0); set_seq(0, 0);
    act_req = 8'hFF;
    settle();
    chk("ar_act_c0", act_gnt, 8'h01);
    tick();
    rd_req = 8'h04;
    settle();
    chk("ar_noact_c1", act_gnt, 8'h00);
    chk("ar_rd_c1", rd_gnt, 8'h04);
    tick();
    set_seq(2, 1);
    settle();
    chk("ar_rd_c2", rd_gnt, 8'h04);
    tick();
    rd_req = 8'h00; wr_req = 8'h01;
    settle();
    chk("ar_nowr_c3", cmd_wr, 1'b0);
    tick();
    settle();
    chk("ar_mode_c4", wr_mode, 1'b1);
    chk("ar_wr_c4", wr_gnt, 8'h01);
    rst = 1'b1;
    #1;
    chk("ar_rst_gnt", {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}, 40'h0);
    chk("ar_rst_mode", wr_mode, 1'b0);
    rst = 1'b0;
    wr_req = 8'h00;
    #1;
    chk("ar_post_act", act_gnt, 8'h01);
    tick();
    act_req = 8'h00; rd_req = 8'h04; set_seq(2, 0);
    settle();
    chk("ar_post_rdseq", rd_gnt, 8'h04);
    chk("ar_post_mode", wr_mode, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
